// File: rtl/tick_scheduler_if.sv
// Configuration handshake bundle for tick_scheduler: a valid/ready channel
// carrying a target channel index and a new divide ratio.
interface tick_scheduler_if #(
   parameter int unsigned CNT_W = 16
);
   logic             cfg_valid_i;
   logic             cfg_ready_o;
   logic [1:0]       cfg_ch_i;
   logic [CNT_W-1:0] cfg_div_i;

   modport master (
      output cfg_valid_i,
      output cfg_ch_i,
      output cfg_div_i,
      input  cfg_ready_o
   );

   modport slave (
      input  cfg_valid_i,
      input  cfg_ch_i,
      input  cfg_div_i,
      output cfg_ready_o
   );
endinterface

// File: rtl/tick_scheduler.sv
// Shared time base: one prescaler produces a base tick, and three channels
// divide it down to a one-cycle tick strobe and a 50% duty square wave each.
// Divide ratios can be rewritten at run time through the config handshake.
module tick_scheduler #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned BASE_HZ = 1000,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned DIV_RST = 250
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           en_i,
   tick_scheduler_if.slave cfg,
   output logic [2:0]     tick_o,
   output logic [2:0]     sq_o,
   output logic           run_o
);

   localparam int unsigned PRE      = CLK_HZ / BASE_HZ;
   localparam int unsigned PRE_W    = (PRE > 1) ? $clog2(PRE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LOAD = 2'd2
   } state_t;

   state_t           state_q;
   logic             ready_q;
   logic [PRE_W-1:0] pre_q;
   logic [CNT_W-1:0] div_q [3];
   logic [CNT_W-1:0] cnt_q [3];

   logic             xfer;
   logic             base_tick;
   logic [2:0]       hit;
   logic [2:0]       term;

   assign cfg.cfg_ready_o = ready_q;

   // Handshake decode, base tick, per-channel write hit and terminal count.
   always_comb begin
      xfer      = cfg.cfg_valid_i & ready_q;
      base_tick = (state_q == RUN) && (pre_q == PRE_LAST);
      hit       = '0;
      term      = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         hit[k]  = xfer && (cfg.cfg_ch_i == 2'(k));
         term[k] = (cnt_q[k] == (div_q[k] - CNT_ONE));
      end
   end

   // Control FSM; ready and run are registered from the next state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         run_o   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, RUN: begin
               if (xfer) begin
                  state_q <= LOAD;
                  ready_q <= 1'b0;
                  run_o   <= 1'b0;
               end else if (en_i) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
                  run_o   <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  run_o   <= 1'b0;
               end
            end
            LOAD: begin
               ready_q <= 1'b1;
               if (en_i) begin
                  state_q <= RUN;
                  run_o   <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  run_o   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               run_o   <= 1'b0;
            end
         endcase
      end
   end

   // Prescaler: counts in RUN, holds through LOAD, cleared while idle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pre_q <= '0;
      end else begin
         case (state_q)
            RUN:     pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
            LOAD:    pre_q <= pre_q;
            default: pre_q <= '0;
         endcase
      end
   end

   // Channel dividers; a config write to a channel wins over its base tick.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < 3; k++) begin
            div_q[k] <= DIV_INIT;
            cnt_q[k] <= '0;
         end
         sq_o   <= '0;
         tick_o <= '0;
      end else begin
         for (int unsigned k = 0; k < 3; k++) begin
            tick_o[k] <= 1'b0;
            if (hit[k]) begin
               div_q[k] <= cfg.cfg_div_i;
               cnt_q[k] <= '0;
               sq_o[k]  <= 1'b0;
            end else if (div_q[k] == '0) begin
               cnt_q[k] <= '0;
               sq_o[k]  <= 1'b0;
            end else if (base_tick) begin
               if (term[k]) begin
                  cnt_q[k]  <= '0;
                  sq_o[k]   <= ~sq_o[k];
                  tick_o[k] <= 1'b1;
               end else begin
                  cnt_q[k] <= cnt_q[k] + CNT_ONE;
               end
            end
         end
      end
   end

endmodule
